text_pixel_pipeline: RTL

- Parametrised, pipelined character-cell pixel generator for the VGA text path.
- Takes the in-cell glyph coordinates and character attributes for the current pixel.
- Drives a registered lookup to an external combinational font ROM, selects the glyph bit, applies blink/cursor/reverse-video modifiers, and outputs a colour pixel with fixed 2-cycle latency.
- Sits between the VGA timing/text-buffer stage and the DAC/colour output register.

---
 rtl/text_pixel_pipeline.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/text_pixel_pipeline.sv
// Character-cell pixel generator: registered font ROM address, glyph bit
// select, blink/cursor/reverse modifiers, colour out with 2-cycle latency.
module text_pixel_pipeline #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLOR_W      = 3,
  parameter int BLINK_FRAMES = 16,
  parameter int CURSOR_TOP   = 14,
  parameter int XW           = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  parameter int YW           = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic [XW-1:0]      glyph_x,
  input  logic [YW-1:0]      glyph_y,
  input  logic [7:0]         char_ascii,
  input  logic [COLOR_W-1:0] char_fg,
  input  logic [COLOR_W-1:0] char_bg,
  input  logic               char_blink,
  input  logic               char_reverse,
  input  logic               cursor_en,
  input  logic               cursor_here,
  output logic [7:0]         font_ascii,
  output logic [YW-1:0]      font_row,
  input  logic [GLYPH_W-1:0] font_pixels,
  output logic               pix_valid,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_on,
  output logic               blink_phase
);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // vld_pipe[0] = stage-1 valid, vld_pipe[1] = pix_valid
  logic [1:0]         vld_pipe_q, vld_pipe_d;
  logic [XW-1:0]      s1_x_q, s1_x_d;
  logic [YW-1:0]      s1_y_q, s1_y_d;
  logic [COLOR_W-1:0] s1_fg_q, s1_fg_d, s1_bg_q, s1_bg_d;
  logic               s1_blink_q, s1_blink_d, s1_rev_q, s1_rev_d;
  logic               s1_cur_q, s1_cur_d, s1_phase_q, s1_phase_d;
  logic [7:0]         font_ascii_q, font_ascii_d;
  logic [YW-1:0]      font_row_q, font_row_d;
  logic [COLOR_W-1:0] pix_color_q, pix_color_d;
  logic               pix_on_q, pix_on_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [GLYPH_W-1:0] row_lr;   // row_lr[i] = pixel at column i (MSB of ROM is leftmost)
  logic               glyph_bit;
  logic [COLOR_W-1:0] col_f, col_b;

  // Stage 1: capture pixel attributes; ROM address only advances on valid pixels
  always_comb begin
    vld_pipe_d    = {vld_pipe_q[0], in_valid};
    s1_x_d        = glyph_x;
    s1_y_d        = glyph_y;
    s1_fg_d       = char_fg;
    s1_bg_d       = char_bg;
    s1_blink_d    = char_blink;
    s1_rev_d      = char_reverse;
    s1_cur_d      = cursor_en & cursor_here;
    s1_phase_d    = blink_phase_q;  // pre-update phase, even with coincident frame_start
    font_ascii_d  = font_ascii_q;
    font_row_d    = font_row_q;
    if (in_valid) begin
      font_ascii_d = char_ascii;
      font_row_d   = glyph_y;
    end
  end

  // Blink counter: phase toggles once every BLINK_FRAMES frame_start pulses
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (32'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Stage 2: select glyph bit, apply blink/cursor/reverse, blank invalid pixels
  always_comb begin
    for (int i = 0; i < GLYPH_W; i++) row_lr[i] = font_pixels[GLYPH_W-1-i];
    glyph_bit = 1'b0;
    if (32'(s1_x_q) < GLYPH_W) glyph_bit = row_lr[s1_x_q];
    if (s1_blink_q && s1_phase_q) glyph_bit = 1'b0;
    if (s1_cur_q && !s1_phase_q && (32'(s1_y_q) >= CURSOR_TOP)) glyph_bit = 1'b1;
    col_f       = s1_rev_q ? s1_bg_q : s1_fg_q;
    col_b       = s1_rev_q ? s1_fg_q : s1_bg_q;
    pix_color_d = '0;
    pix_on_d    = 1'b0;
    if (vld_pipe_q[0]) begin
      pix_color_d = glyph_bit ? col_f : col_b;
      pix_on_d    = glyph_bit;
    end
  end

  // All state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q    <= '0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_fg_q       <= '0;
      s1_bg_q       <= '0;
      s1_blink_q    <= 1'b0;
      s1_rev_q      <= 1'b0;
      s1_cur_q      <= 1'b0;
      s1_phase_q    <= 1'b0;
      font_ascii_q  <= '0;
      font_row_q    <= '0;
      pix_color_q   <= '0;
      pix_on_q      <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      s1_x_q        <= s1_x_d;
      s1_y_q        <= s1_y_d;
      s1_fg_q       <= s1_fg_d;
      s1_bg_q       <= s1_bg_d;
      s1_blink_q    <= s1_blink_d;
      s1_rev_q      <= s1_rev_d;
      s1_cur_q      <= s1_cur_d;
      s1_phase_q    <= s1_phase_d;
      font_ascii_q  <= font_ascii_d;
      font_row_q    <= font_row_d;
      pix_color_q   <= pix_color_d;
      pix_on_q      <= pix_on_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign font_ascii  = font_ascii_q;
  assign font_row    = font_row_q;
  assign pix_valid   = vld_pipe_q[1];
  assign pix_color   = pix_color_q;
  assign pix_on      = pix_on_q;
  assign blink_phase = blink_phase_q;
endmodule
